// File: rtl/flow_writer_if.sv
// Solver-result input channel and flow-BRAM write channel of flow_writer.
// master drives results and grant; slave (flow_writer) drives ready and the write port.
interface flow_writer_if #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int ADDR_WIDTH = 18,
  parameter int FLOW_WIDTH = 16
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic                    in_valid;
  logic                    in_ready;
  logic [XW-1:0]           in_x;
  logic [YW-1:0]           in_y;
  logic [FLOW_WIDTH-1:0]   in_u;
  logic [FLOW_WIDTH-1:0]   in_v;
  logic                    wr_grant;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [2*FLOW_WIDTH-1:0] wr_data;

  modport master (
    output in_valid, in_x, in_y, in_u, in_v, wr_grant,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_x, in_y, in_u, in_v, wr_grant,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/flow_writer.sv
// Buffers solver flow vectors in a small FIFO and writes {u,v} to the flow BRAM at y*WIDTH+x; pulses done after a full frame.
// Handshake to wr_en is 2 cycles; in_ready is registered from occupancy. FLOW_WRITER_ORDER_CHECK_EN adds a raster-order checker.
module flow_writer #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int ADDR_WIDTH = 18,
  parameter int FLOW_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  flow_writer_if.slave     bus,
  output logic             busy,
  output logic             done,
  output logic             coord_err,
  output logic             order_err
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] TOTAL = ADDR_WIDTH'(WIDTH * HEIGHT);

  typedef enum logic [1:0] {IDLE, WRITE, DONE_ST} state_t;

  typedef struct packed {
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [FLOW_WIDTH-1:0] u;
    logic [FLOW_WIDTH-1:0] v;
  } entry_t;

  state_t                  state_q, state_d;
  entry_t                  mem_q [FIFO_DEPTH];
  entry_t                  mem_d [FIFO_DEPTH];
  logic [PW:0]             wp_q, wp_d, rp_q, rp_d, occ_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d, wr_addr_q, wr_addr_d;
  logic [2*FLOW_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                    wr_en_q, wr_en_d, in_ready_q, in_ready_d;
  logic                    done_q, done_d, coord_err_q, coord_err_d;
  logic                    push, pop, empty, head_ok;
  entry_t                  head, in_entry;

  assign in_entry = '{x: bus.in_x, y: bus.in_y, u: bus.in_u, v: bus.in_v};
  assign empty    = (wp_q == rp_q);
  assign head     = mem_q[rp_q[PW-1:0]];
  assign head_ok  = (32'(head.x) < WIDTH) && (32'(head.y) < HEIGHT);
  // in_ready_q is only ever high in WRITE, so it alone qualifies a push.
  assign push     = bus.in_valid && in_ready_q;
  assign pop      = (state_q == WRITE) && !empty && bus.wr_grant;

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    cnt_d       = cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    done_d      = 1'b0;
    coord_err_d = coord_err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WRITE;
          wp_d        = '0;
          rp_d        = '0;
          cnt_d       = '0;
          coord_err_d = 1'b0;
        end
      end
      WRITE: begin
        if (push) begin
          mem_d[wp_q[PW-1:0]] = in_entry;
          wp_d                = wp_q + 1'b1;
        end
        if (pop) begin
          rp_d = rp_q + 1'b1;
          if (head_ok) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_WIDTH'(head.y) * ADDR_WIDTH'(WIDTH) + ADDR_WIDTH'(head.x);
            wr_data_d = {head.u, head.v};
            cnt_d     = cnt_q + 1'b1;
            if (cnt_d == TOTAL) state_d = DONE_ST;
          end else begin
            coord_err_d = 1'b1;
          end
        end
      end
      DONE_ST: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    occ_d      = wp_d - rp_d;
    // Occupancy never exceeds FIFO_DEPTH, so the MSB alone flags full.
    in_ready_d = (state_d == WRITE) && !occ_d[PW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      coord_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      in_ready_q  <= in_ready_d;
      done_q      <= done_d;
      coord_err_q <= coord_err_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef FLOW_WRITER_ORDER_CHECK_EN
  logic [XW-1:0] ex_q, ex_d;
  logic [YW-1:0] ey_q, ey_d;
  logic          order_err_q, order_err_d;
  logic          in_ok;

  assign in_ok = (32'(bus.in_x) < WIDTH) && (32'(bus.in_y) < HEIGHT);

  // Expected position always resyncs to the received coordinate + 1.
  always_comb begin
    ex_d        = ex_q;
    ey_d        = ey_q;
    order_err_d = order_err_q;
    if (state_q == IDLE && start) begin
      ex_d        = '0;
      ey_d        = '0;
      order_err_d = 1'b0;
    end else if (push && in_ok) begin
      if (bus.in_x != ex_q || bus.in_y != ey_q) order_err_d = 1'b1;
      if (32'(bus.in_x) == WIDTH - 1) begin
        ex_d = '0;
        ey_d = (32'(bus.in_y) == HEIGHT - 1) ? '0 : bus.in_y + 1'b1;
      end else begin
        ex_d = bus.in_x + 1'b1;
        ey_d = bus.in_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      ey_q        <= '0;
      order_err_q <= 1'b0;
    end else begin
      ex_q        <= ex_d;
      ey_q        <= ey_d;
      order_err_q <= order_err_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign coord_err    = coord_err_q;
endmodule

// File: tb/tb_flow_writer.sv
// Scoreboard bench for flow_writer on a 5x2 frame (non-power-of-two width so x=5 is representable and out of range).
module tb_flow_writer;
  localparam int W = 5, H = 2, AW = 18, FW = 16, DEPTH = 4;
`ifdef FLOW_WRITER_ORDER_CHECK_EN
  localparam logic ORDER_EXP = 1'b1;
`else
  localparam logic ORDER_EXP = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0]   addr;
    logic [2*FW-1:0] data;
    int              cyc;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic busy, done, coord_err, order_err;
  int   n_cmp = 0, n_err = 0, cyc = 0, wr_cnt = 0, done_cnt = 0, acc_cnt = 0, last_wr_cyc = -10;
  int   base_wr, base_done;
  exp_t exp_q[$];

  flow_writer_if #(.WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW), .FLOW_WIDTH(FW)) bus ();

  flow_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW), .FLOW_WIDTH(FW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .coord_err(coord_err), .order_err(order_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write, checks done follows the last write.
  always @(negedge clk) begin : mon
    exp_t it;
    if (rst_n) begin
      if (bus.wr_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0h data %0h, none queued", bus.wr_addr, bus.wr_data);
        end else begin
          it = exp_q.pop_front();
          check("wr_addr", 64'(bus.wr_addr), 64'(it.addr));
          check("wr_data", 64'(bus.wr_data), 64'(it.data));
          if (it.cyc >= 0) check("wr_latency", 64'(cyc), 64'(it.cyc));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_timing", 64'(cyc), 64'(last_wr_cyc + 1));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send(input int x, input int y, input logic [FW-1:0] u, input logic [FW-1:0] v,
                      input bit exp_wr, input int exp_addr, input bit timed);
    int  waited = 0;
    bit  ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_x = 3'(x);
    bus.in_y = 1'(y);
    bus.in_u = u;
    bus.in_v = v;
    while (!ok && waited < 60) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        acc_cnt++;
        if (exp_wr) exp_q.push_back('{AW'(exp_addr), {u, v}, timed ? cyc + 2 : -1});
      end
      tick(1);
      waited++;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: x=%0d y=%0d not accepted within %0d cycles", x, y, waited);
    end
  endtask

  task automatic send_run(input int first, input int n, input logic [FW-1:0] tag, input bit timed);
    for (int p = first; p < first + n; p++)
      send(p % W, p / W, tag + FW'(p), ~(tag + FW'(p)), 1'b1, p, timed);
  endtask

  task automatic wait_done(input int base, input string tname);
    int k = 0;
    while (done_cnt == base && k < 200) begin
      tick(1);
      k++;
    end
    tick(3);
    check({tname, "_done_pulses"}, 64'(done_cnt - base), 64'd1);
    check({tname, "_busy_after"}, 64'(busy), 64'd0);
    check({tname, "_ready_after"}, 64'(bus.in_ready), 64'd0);
  endtask

  task automatic wait_drain(input string tname);
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick(1);
      k++;
    end
    tick(2);
    check({tname, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int rej;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_y = '0;
    bus.in_u = '0;
    bus.in_v = '0;
    bus.wr_grant = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ctrl", 64'({bus.in_ready, bus.wr_en, busy, done, coord_err, order_err}), 64'd0);
    check("rst_addr", 64'(bus.wr_addr), 64'd0);
    check("rst_data", 64'(bus.wr_data), 64'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("idle_ready", 64'(bus.in_ready), 64'd0);

    // Full raster frame, grant held, each write 2 cycles after handshake.
    bus.wr_grant = 1'b1;
    base_done = done_cnt;
    base_wr = wr_cnt;
    pulse_start();
    check("busy_in_write", 64'(busy), 64'd1);
    send_run(0, 10, 16'h1100, 1'b1);
    wait_done(base_done, "frame");
    check("frame_writes", 64'(wr_cnt - base_wr), 64'd10);
    rej = 0;
    bus.in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.in_ready) rej++;
    end
    tick(1);
    bus.in_valid = 1'b0;
    check("accept_after_done", 64'(rej), 64'd0);

    // Backpressure: grant low, FIFO fills at 4, then drains in order.
    bus.wr_grant = 1'b0;
    base_done = done_cnt;
    base_wr = wr_cnt;
    acc_cnt = 0;
    pulse_start();
    fork
      send_run(0, 6, 16'h2200, 1'b0);
      begin
        tick(14);
        check("bp_accepted", 64'(acc_cnt), 64'd4);
        check("bp_ready_low", 64'(bus.in_ready), 64'd0);
        check("bp_no_writes", 64'(wr_cnt - base_wr), 64'd0);
        bus.wr_grant = 1'b1;
      end
    join
    wait_drain("bp");
    check("bp_writes", 64'(wr_cnt - base_wr), 64'd6);
    send_run(6, 4, 16'h2200, 1'b1);
    wait_done(base_done, "bp");

    // Out-of-range x=5 is dropped and flags coord_err; done still needs 10 valid writes.
    base_done = done_cnt;
    base_wr = wr_cnt;
    pulse_start();
    send_run(0, 3, 16'h3300, 1'b1);
    send(5, 0, 16'hDEAD, 16'hBEEF, 1'b0, 0, 1'b0);
    send_run(3, 7, 16'h3300, 1'b1);
    wait_done(base_done, "oor");
    check("oor_writes", 64'(wr_cnt - base_wr), 64'd10);
    check("oor_coord_err", 64'(coord_err), 64'd1);

    // Next start clears coord_err; a start while busy is ignored.
    base_done = done_cnt;
    pulse_start();
    check("start_clears_coord_err", 64'(coord_err), 64'd0);
    send_run(0, 4, 16'h4400, 1'b1);
    pulse_start();
    check("busy_start_ignored", 64'(busy), 64'd1);
    send_run(4, 6, 16'h4400, 1'b1);
    wait_done(base_done, "busy_start");

    // Reset mid-frame after 3 writes with 2 entries still queued.
    base_wr = wr_cnt;
    pulse_start();
    send_run(0, 3, 16'h5500, 1'b1);
    tick(4);
    bus.wr_grant = 1'b0;
    send(3, 0, 16'h5AAA, 16'h5BBB, 1'b0, 0, 1'b0);
    send(4, 0, 16'h5CCC, 16'h5DDD, 1'b0, 0, 1'b0);
    tick(3);
    check("pre_rst_writes", 64'(wr_cnt - base_wr), 64'd3);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", 64'({bus.in_ready, bus.wr_en, busy, done, coord_err, order_err}), 64'd0);
    check("midrst_addr", 64'(bus.wr_addr), 64'd0);
    check("midrst_data", 64'(bus.wr_data), 64'd0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    bus.wr_grant = 1'b1;
    base_wr = wr_cnt;
    tick(6);
    check("no_stale_writes", 64'(wr_cnt - base_wr), 64'd0);
    base_done = done_cnt;
    pulse_start();
    send_run(0, 10, 16'h6600, 1'b1);
    wait_done(base_done, "post_rst");
    check("post_rst_writes", 64'(wr_cnt - base_wr), 64'd10);

    // Raster-order violation at the second result; writes go to 0, 2, 3.
    pulse_start();
    send(0, 0, 16'h7000, 16'h7100, 1'b1, 0, 1'b1);
    check("order_first", 64'(order_err), 64'd0);
    send(2, 0, 16'h7002, 16'h7102, 1'b1, 2, 1'b1);
    check("order_skip", 64'(order_err), 64'(ORDER_EXP));
    send(3, 0, 16'h7003, 16'h7103, 1'b1, 3, 1'b1);
    check("order_sticky", 64'(order_err), 64'(ORDER_EXP));
    wait_drain("order");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
